// File: rtl/pe_result_drain_if.sv
// ---------------------------------------------------------------------------
// pe_result_drain_if
//
// Lane-serial writeback stream leaving the PE result drain.
//
// Signals:
//   out_data   lane value presented to the consumer
//   out_lane   lane index of out_data
//   out_last   high when out_lane is the final lane of the vector
//   out_valid  lane data available
//   out_ready  consumer accepts the current lane
//
// Modports:
//   master  the drain (drives data/lane/last/valid, samples ready)
//   slave   the writeback consumer
// ---------------------------------------------------------------------------
interface pe_result_drain_if #(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 4
);
    logic [REG_WIDTH-1:0]       out_data;
    logic [$clog2(VECTOR)-1:0]  out_lane;
    logic                       out_last;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output out_data,
        output out_lane,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_lane,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/pe_result_drain.sv
// ---------------------------------------------------------------------------
// pe_result_drain
//
// Drain stage behind the last PE of the vector column. Each c_valid strobe
// captures a VECTOR-wide result vector into a DEPTH-entry circular FIFO; the
// FIFO head is then serialised lane by lane onto a valid/ready stream. The
// array is free-running, so a strobe into a full FIFO is dropped and flagged
// in the sticky overflow bit rather than stalling anything upstream.
//
// Parameters:
//   REG_WIDTH  lane width in bits
//   VECTOR     lanes per vector (>= 2)
//   DEPTH      FIFO depth in vectors (power of two, >= 2)
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   c_in      result vector from the last PE
//   c_valid   capture strobe from the array controller
//   in_ready  FIFO not full (informational only)
//   level     number of vectors held
//   overflow  sticky: a strobed vector was dropped
//   out_if    lane-serial output stream (master modport)
//
// Configuration:
//   DRAIN_RELU_EN  when defined, negative lanes (MSB set) are presented as 0
//                  on out_data; stored values are never altered.
// ---------------------------------------------------------------------------
module pe_result_drain #(
    parameter int REG_WIDTH = 16,
    parameter int VECTOR    = 4,
    parameter int DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_WIDTH-1:0]      c_in [VECTOR-1:0],
    input  logic                      c_valid,
    output logic                      in_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    pe_result_drain_if.master         out_if
);

    localparam int LW = $clog2(VECTOR);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   LEVEL_FULL = (PW+1)'(DEPTH);
    localparam logic [LW-1:0] LANE_LAST  = LW'(VECTOR-1);

    logic [REG_WIDTH-1:0] mem [DEPTH][VECTOR];
    logic [PW-1:0]        wp;
    logic [PW-1:0]        rp;
    logic [LW-1:0]        lane;

    logic full;
    logic push;
    logic xfer;
    logic pop;
    logic [REG_WIDTH-1:0] head_lane;

    // Full is judged on the registered level, so a pop in the same cycle
    // does not make room for a strobe into a full FIFO.
    assign full     = (level == LEVEL_FULL);
    assign push     = c_valid && !full;
    assign xfer     = out_if.out_valid && out_if.out_ready;
    assign pop      = xfer && (lane == LANE_LAST);
    assign in_ready = !full;

    // Storage and write pointer; storage is cleared on reset so out_data
    // reads as 0 from entry 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                for (int l = 0; l < VECTOR; l++) begin
                    mem[d][l] <= '0;
                end
            end
        end else if (push) begin
            for (int l = 0; l < VECTOR; l++) begin
                mem[wp][l] <= c_in[l];
            end
            wp <= wp + 1'b1;
        end
    end

    // Read side: the lane counter only moves on a transfer, so it sits at 0
    // while idle and holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp   <= '0;
            lane <= '0;
        end else if (xfer) begin
            if (pop) begin
                lane <= '0;
                rp   <= rp + 1'b1;
            end else begin
                lane <= lane + 1'b1;
            end
        end
    end

    // Occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (c_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head_lane = mem[rp][lane];

    // Outputs depend on registers only; out_ready never reaches them.
    assign out_if.out_valid = (level != '0);
    assign out_if.out_lane  = lane;
    assign out_if.out_last  = (lane == LANE_LAST);
`ifdef DRAIN_RELU_EN
    assign out_if.out_data  = head_lane[REG_WIDTH-1] ? '0 : head_lane;
`else
    assign out_if.out_data  = head_lane;
`endif

endmodule

// File: tb/tb_pe_result_drain.sv
// ---------------------------------------------------------------------------
// tb_pe_result_drain
//
// Self-checking bench for pe_result_drain (REG_WIDTH=16, VECTOR=4, DEPTH=4).
// The stimulus process pushes the hand-computed lane sequence of every kept
// vector into a scoreboard queue; a monitor pops and compares each accepted
// lane. Level, overflow, reset and backpressure behaviour are checked inline.
// ---------------------------------------------------------------------------
module tb_pe_result_drain;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  lane;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] c_in [3:0];
    logic        c_valid;
    logic        in_ready;
    logic [2:0]  level;
    logic        overflow;

    pe_result_drain_if #(.REG_WIDTH(16), .VECTOR(4)) out_if ();

    pe_result_drain #(
        .REG_WIDTH(16),
        .VECTOR(4),
        .DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .c_in     (c_in),
        .c_valid  (c_valid),
        .in_ready (in_ready),
        .level    (level),
        .overflow (overflow),
        .out_if   (out_if)
    );

    beat_t expq [$];
    int    numChecks = 0;
    int    numFails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the stimulus process.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpect(input logic [63:0] vec);
        for (int i = 0; i < 4; i++) begin
            expq.push_back('{data: vec[16*i +: 16], lane: 2'(i), last: (i == 3)});
        end
    endtask

    // Strobes one vector (lane i = vec[16*i +: 16]) for a single edge.
    task automatic applyStimulus(input logic [63:0] vec, input bit kept);
        for (int i = 0; i < 4; i++) begin
            c_in[i] = vec[16*i +: 16];
        end
        if (kept) pushExpect(vec);
        c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int cyc = 0;
        while ((expq.size() != 0 || level != 3'd0) && cyc < 200) begin
            tick();
            cyc++;
        end
        checkOutput({name, " drained"}, 32'((expq.size() == 0) && (level == 3'd0)), 32'd1);
        checkOutput({name, " valid low"}, 32'(out_if.out_valid), 32'd0);
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, " out_valid"}, 32'(out_if.out_valid), 32'd0);
        checkOutput({name, " in_ready"},  32'(in_ready),         32'd1);
        checkOutput({name, " out_lane"},  32'(out_if.out_lane),  32'd0);
        checkOutput({name, " out_last"},  32'(out_if.out_last),  32'd0);
        checkOutput({name, " out_data"},  32'(out_if.out_data),  32'd0);
        checkOutput({name, " level"},     32'(level),            32'd0);
        checkOutput({name, " overflow"},  32'(overflow),         32'd0);
    endtask

    // Monitor: every lane accepted at the coming rising edge must match the
    // head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_if.out_valid && out_if.out_ready) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected lane", {16'h0, out_if.out_data}, 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = expq.pop_front();
                checkOutput("lane data", 32'(out_if.out_data), 32'(e.data));
                checkOutput("lane index", 32'(out_if.out_lane), 32'(e.lane));
                checkOutput("lane last", 32'(out_if.out_last), 32'(e.last));
            end
        end
    end

    initial begin
        rst_n            = 1'b0;
        c_valid          = 1'b0;
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) c_in[i] = 16'h0;

        // Reset state
        tick();
        tick();
        checkReset("reset");
        rst_n = 1'b1;
        tick();

        // Single vector, latency and drain timing
        $display("[TB] single vector");
        out_if.out_ready = 1'b1;
        applyStimulus({16'd4, 16'd3, 16'd2, 16'd1}, 1'b1);
        checkOutput("single level after strobe", 32'(level), 32'd1);
        checkOutput("single valid after strobe", 32'(out_if.out_valid), 32'd1);
        checkOutput("single lane0 first", 32'(out_if.out_lane), 32'd0);
        repeat (3) tick();
        checkOutput("single level before last", 32'(level), 32'd1);
        tick();
        checkOutput("single level after last", 32'(level), 32'd0);
        waitDrain("single");

        // Backpressure on lane 2
        $display("[TB] backpressure");
        applyStimulus({16'd14, 16'd13, 16'd12, 16'd11}, 1'b1);
        tick();
        tick();
        out_if.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold lane", 32'(out_if.out_lane), 32'd2);
            checkOutput("hold data", 32'(out_if.out_data), 32'd13);
            checkOutput("hold valid", 32'(out_if.out_valid), 32'd1);
            checkOutput("hold last", 32'(out_if.out_last), 32'd0);
            tick();
        end
        out_if.out_ready = 1'b1;
        waitDrain("backpressure");

        // Overflow: fill four, drop the fifth
        $display("[TB] overflow and wrap");
        out_if.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            logic [15:0] b;
            b = 16'(k * 16'h100);
            applyStimulus({b + 16'd3, b + 16'd2, b + 16'd1, b}, k <= 4);
            checkOutput("fill level", 32'(level), (k <= 4) ? 32'(k) : 32'd4);
            checkOutput("fill overflow", 32'(overflow), (k <= 4) ? 32'd0 : 32'd1);
            checkOutput("fill in_ready", 32'(in_ready), (k >= 4) ? 32'd0 : 32'd1);
        end
        tick();
        checkOutput("overflow sticky", 32'(overflow), 32'd1);
        out_if.out_ready = 1'b1;
        waitDrain("overflow");

        // Six more vectors, one per lane-period, wrapping both pointers
        for (int k = 0; k < 6; k++) begin
            logic [15:0] b;
            b = 16'(16'hA000 + k * 16'h10);
            applyStimulus({b + 16'd3, b + 16'd2, b + 16'd1, b}, 1'b1);
            checkOutput("wrap level", 32'(level), 32'd1);
            repeat (3) tick();
        end
        waitDrain("wrap");
        checkOutput("overflow still sticky", 32'(overflow), 32'd1);

        // Simultaneous push and pop at level 2
        $display("[TB] push with pop");
        out_if.out_ready = 1'b0;
        applyStimulus({16'h0B03, 16'h0B02, 16'h0B01, 16'h0B00}, 1'b1);
        applyStimulus({16'h0C03, 16'h0C02, 16'h0C01, 16'h0C00}, 1'b1);
        checkOutput("pp level before", 32'(level), 32'd2);
        out_if.out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("pp on last lane", 32'(out_if.out_lane), 32'd3);
        applyStimulus({16'h0D03, 16'h0D02, 16'h0D01, 16'h0D00}, 1'b1);
        checkOutput("pp level after", 32'(level), 32'd2);
        checkOutput("pp next lane", 32'(out_if.out_lane), 32'd0);
        checkOutput("pp next data", 32'(out_if.out_data), 32'h0C00);
        waitDrain("push-pop");

        // Reset in the middle of a stream
        $display("[TB] reset mid-stream");
        out_if.out_ready = 1'b0;
        applyStimulus({16'h0E03, 16'h0E02, 16'h0E01, 16'h0E00}, 1'b1);
        applyStimulus({16'h0F03, 16'h0F02, 16'h0F01, 16'h0F00}, 1'b1);
        applyStimulus({16'h1003, 16'h1002, 16'h1001, 16'h1000}, 1'b1);
        out_if.out_ready = 1'b1;
        tick();
        checkOutput("mid lane before reset", 32'(out_if.out_lane), 32'd1);
        out_if.out_ready = 1'b0;
        rst_n = 1'b0;
        expq.delete();
        #1;
        checkReset("mid reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        out_if.out_ready = 1'b1;
        applyStimulus({16'h2003, 16'h2002, 16'h2001, 16'h2000}, 1'b1);
        checkOutput("post reset lane", 32'(out_if.out_lane), 32'd0);
        checkOutput("post reset data", 32'(out_if.out_data), 32'h2000);
        waitDrain("post reset");

        // Sign handling of the presented data
        $display("[TB] relu option");
`ifdef DRAIN_RELU_EN
        pushExpect({16'h0005, 16'h0000, 16'h0000, 16'h7FFF});
`else
        pushExpect({16'h0005, 16'hFFFF, 16'h8000, 16'h7FFF});
`endif
        applyStimulus({16'h0005, 16'hFFFF, 16'h8000, 16'h7FFF}, 1'b0);
        waitDrain("relu");
        checkOutput("final overflow", 32'(overflow), 32'd0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
